// File: rtl/if_stage_pkg.sv
// if_stage_pkg: definitions shared by the fetch stage and decode/control.
//   state_e        fetch controller states
//   *_DEF          default reset PC and NOP instruction word
//   *_MSB/*_LSB    instruction field positions (op, funct, rt)
//   pc_plus4       sequential next-PC, wraps modulo 2^32
package if_stage_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DROP  = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;  // sll $0,$0,0

  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned RT_MSB    = 20;
  localparam int unsigned RT_LSB    = 16;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clk_i, rst_i    clock, asynchronous active-high reset
//   bubble_i        load NOP / pc4=0 / valid=0 (highest priority)
//   load_i          load instr_i / pc4_i as a live instruction
//   instr_o, pc4_o, valid_o   register contents
// Neither bubble_i nor load_i asserted holds the register (stall).
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bubble_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (bubble_i) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with stall, flush and redirect handling.
//   clk, reset                  clock, asynchronous active-high reset
//   stall, flush                hazard unit controls
//   redirect_valid/redirect_pc  taken branch/jump target
//   imem_req/addr/ready/rdata   instruction memory handshake
//   if_id_instr/pc4/valid       IF/ID register
//   if_id_op/funct/rt           fields decoded straight from if_id_instr
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  if_id_op,
  output logic [5:0]  if_id_funct,
  output logic [4:0]  if_id_rt
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  // Redirect target parked while an abandoned request drains in DROP;
  // pc_q keeps driving the old address so the request stays stable.
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] hb_instr_q, hb_instr_d;
  logic [31:0] hb_pc4_q, hb_pc4_d;

  logic        bubble, load;
  logic [31:0] ld_instr, ld_pc4;
  logic [31:0] pc4;

  assign pc4 = pc_plus4(pc_q);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    hb_instr_d = hb_instr_q;
    hb_pc4_d   = hb_pc4_q;
    bubble     = 1'b0;
    load       = 1'b0;
    ld_instr   = hb_instr_q;
    ld_pc4     = hb_pc4_q;

    if (redirect_valid) begin
      bubble = 1'b1;
      if (state_q != HOLD && !imem_ready) begin
        tgt_d   = redirect_pc;
        state_d = DROP;
      end else begin
        pc_d    = redirect_pc;
        state_d = FETCH;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ready) begin
            pc_d = pc4;
            if (stall) begin
              hb_instr_d = imem_rdata;
              hb_pc4_d   = pc4;
              state_d    = HOLD;
            end else begin
              load     = 1'b1;
              ld_instr = imem_rdata;
              ld_pc4   = pc4;
            end
            bubble = flush;
          end else begin
            bubble = flush | ~stall;
          end
        end
        DROP: begin
          bubble = flush | ~stall;
          if (imem_ready) begin
            pc_d    = tgt_q;
            state_d = FETCH;
          end
        end
        HOLD: begin
          if (flush) begin
            bubble  = 1'b1;
            state_d = FETCH;
          end else if (!stall) begin
            load    = 1'b1;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      tgt_q      <= '0;
      hb_instr_q <= '0;
      hb_pc4_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      hb_instr_q <= hb_instr_d;
      hb_pc4_q   <= hb_pc4_d;
    end
  end

  // Gated by reset directly so the request drops asynchronously and the
  // first request appears in the first cycle after release.
  assign imem_req  = ~reset & (state_q != HOLD);
  assign imem_addr = pc_q;

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk_i   (clk),
    .rst_i   (reset),
    .bubble_i(bubble),
    .load_i  (load),
    .instr_i (ld_instr),
    .pc4_i   (ld_pc4),
    .instr_o (if_id_instr),
    .pc4_o   (if_id_pc4),
    .valid_o (if_id_valid)
  );

  assign if_id_op    = if_id_instr[OP_MSB:OP_LSB];
  assign if_id_funct = if_id_instr[FUNCT_MSB:FUNCT_LSB];
  assign if_id_rt    = if_id_instr[RT_MSB:RT_LSB];

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, redirect_valid = 1'b0, imem_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata, if_id_instr, if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  if_id_op, if_id_funct;
  logic [4:0]  if_id_rt;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .if_id_op(if_id_op), .if_id_funct(if_id_funct),
    .if_id_rt(if_id_rt)
  );

  // Reference model: fetch address, an optional pending redirect target
  // (abandoned request still outstanding), an optional held fetched word.
  typedef struct packed { logic [31:0] instr; logic [31:0] pc4; } hb_t;
  logic [31:0] m_addr;
  logic [31:0] m_target[$];
  hb_t         m_held[$];
  logic [31:0] m_instr, m_pc4;
  logic        m_valid;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got=%h expected=%h", tag, got, exp);
  endtask

  task automatic m_bubble();
    m_instr = NOP; m_pc4 = '0; m_valid = 1'b0;
  endtask

  task automatic m_reset();
    m_addr = RST_PC;
    m_target.delete();
    m_held.delete();
    m_bubble();
  endtask

  task automatic model_step(input logic st, input logic fl, input logic rv,
                            input logic [31:0] rpc, input logic rdy);
    logic        req;
    logic [31:0] w, a4;
    hb_t         h;
    req = (m_held.size() == 0);
    w   = mem_word(m_addr);
    a4  = m_addr + 32'd4;
    if (rv) begin
      m_bubble();
      m_held.delete();
      if (req && !rdy) begin
        m_target.delete();
        m_target.push_back(rpc);
      end else begin
        m_addr = rpc;
        m_target.delete();
      end
    end else if (m_target.size() != 0) begin
      if (fl || !st) m_bubble();
      if (rdy) m_addr = m_target.pop_front();
    end else if (!req) begin
      if (fl) begin
        m_bubble();
        m_held.delete();
      end else if (!st) begin
        h = m_held.pop_front();
        m_instr = h.instr; m_pc4 = h.pc4; m_valid = 1'b1;
      end
    end else begin
      if (rdy) begin
        m_addr = a4;
        if (st) begin
          h.instr = w; h.pc4 = a4;
          m_held.push_back(h);
        end else if (!fl) begin
          m_instr = w; m_pc4 = a4; m_valid = 1'b1;
        end
      end
      if (fl || (!rdy && !st)) m_bubble();
    end
  endtask

  task automatic check_all();
    logic [31:0] ins;
    ins = m_instr;
    chk("req",   {31'b0, imem_req}, {31'b0, !reset && m_held.size() == 0});
    chk("addr",  imem_addr, m_addr);
    chk("instr", if_id_instr, m_instr);
    chk("pc4",   if_id_pc4, m_pc4);
    chk("valid", {31'b0, if_id_valid}, {31'b0, m_valid});
    chk("op",    {26'b0, if_id_op}, {26'b0, ins[31:26]});
    chk("funct", {26'b0, if_id_funct}, {26'b0, ins[5:0]});
    chk("rt",    {27'b0, if_id_rt}, {27'b0, ins[20:16]});
  endtask

  // Drive one cycle of inputs (called just after a falling edge), then
  // compare everything at the next falling edge.
  task automatic cyc(input logic st, input logic fl, input logic rv,
                     input logic [31:0] rpc, input logic rdy);
    stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc; imem_ready = rdy;
    model_step(st, fl, rv, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    stall = 0; flush = 0; redirect_valid = 0; imem_ready = 0;
    reset = 1'b1;
    m_reset();
    #1 check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b0;
    #1;
    check_all();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RST_PC);
  endtask

  initial begin
    logic [31:0] r;
    m_reset();
    @(negedge clk);

    // Zero-wait streaming
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("stream_addr", imem_addr, 32'(4 * i));
      cyc(0, 0, 0, '0, 1);
      chk("stream_pc4", if_id_pc4, 32'(4 * (i + 1)));
      chk("stream_valid", {31'b0, if_id_valid}, 32'd1);
    end

    // Stall three cycles on the word at address 8
    do_reset();
    cyc(0, 0, 0, '0, 1);
    cyc(0, 0, 0, '0, 1);
    chk("stall_addr", imem_addr, 32'd8);
    cyc(1, 0, 0, '0, 1);
    chk("hold_req", {31'b0, imem_req}, 32'd0);
    cyc(1, 0, 0, '0, 1);
    chk("hold_req2", {31'b0, imem_req}, 32'd0);
    chk("hold_pc4", if_id_pc4, 32'd8);
    cyc(1, 0, 0, '0, 1);
    cyc(0, 0, 0, '0, 0);
    chk("release_instr", if_id_instr, mem_word(32'd8));
    chk("release_pc4", if_id_pc4, 32'd12);
    chk("release_addr", imem_addr, 32'd12);
    cyc(0, 0, 0, '0, 1);
    chk("after_pc4", if_id_pc4, 32'd16);

    // Slow memory with a redirect during the wait
    do_reset();
    cyc(0, 0, 0, '0, 1);
    cyc(0, 0, 1, 32'h100, 0);
    chk("drop_addr1", imem_addr, 32'd4);
    cyc(0, 0, 0, '0, 0);
    chk("drop_addr2", imem_addr, 32'd4);
    cyc(0, 0, 0, '0, 0);
    chk("drop_addr3", imem_addr, 32'd4);
    cyc(0, 0, 0, '0, 1);
    chk("drop_next", imem_addr, 32'h100);
    chk("drop_valid", {31'b0, if_id_valid}, 32'd0);
    cyc(0, 0, 0, '0, 1);
    chk("target_pc4", if_id_pc4, 32'h104);

    // Flush together with stall
    cyc(1, 1, 0, '0, 1);
    chk("fs_valid", {31'b0, if_id_valid}, 32'd0);
    chk("fs_instr", if_id_instr, NOP);
    cyc(0, 0, 0, '0, 1);

    // Address wrap
    cyc(0, 0, 1, 32'hFFFF_FFFC, 1);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, '0, 1);
    chk("wrap_pc4", if_id_pc4, 32'd0);
    chk("wrap_next", imem_addr, 32'd0);

    // Asynchronous reset in the middle of a wait
    cyc(0, 0, 0, '0, 1);
    cyc(0, 0, 0, '0, 0);
    #2 reset = 1'b1;
    m_reset();
    #1;
    check_all();
    chk("arst_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_addr", imem_addr, RST_PC);
    chk("arst_req2", {31'b0, imem_req}, 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      r[1:0] = 2'b00;
      cyc(($urandom % 4) == 0, ($urandom % 8) == 0, ($urandom % 7) == 0,
          r, ($urandom % 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
